// File: rtl/lsb_decoder24_hs.sv
// Handshaked 2-to-4 one-hot decoder: holds a grant until acknowledged or until HOLD_MAX cycles.
// Optional saturating timeout counter on err_cnt, enabled by LSB_DEC_ERR_COUNT_EN.
module lsb_decoder24_hs #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] idx,
  output logic [3:0] y,
  output logic       y_valid,
  input  logic       y_ack,
  output logic       timeout,
  output logic [7:0] err_cnt
);

  typedef enum logic {StIdle, StActive} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [3:0] y_q, y_d;
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StActive;
          y_d     = 4'b0001 << idx;
          hold_d  = 8'd0;
        end
      end
      StActive: begin
        // Acknowledge takes priority over an expiring hold.
        if (y_ack) begin
          state_d = StIdle;
          y_d     = 4'b0000;
          hold_d  = 8'd0;
        end else if (hold_q == HoldLast) begin
          state_d   = StIdle;
          y_d       = 4'b0000;
          hold_d    = 8'd0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        y_d     = 4'b0000;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      y_q       <= 4'b0000;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign y        = y_q;
  assign y_valid  = |y_q;
  assign timeout  = timeout_q;

`ifdef LSB_DEC_ERR_COUNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 8'd0;
    end else if (timeout_d && (err_q != 8'hff)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
